// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares the single-port SRAM wrapper between the instruction-fetch port (IFU)
// and the load/store port (LSU). Each access runs IDLE -> ISSUE -> WAIT. The
// arbiter always returns to IDLE after an acknowledge, so the wrapper sees the
// strobes low for one cycle between accesses. A watchdog aborts any access
// whose ready never arrives.
//
// Build option: define RAM_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests. Without it, the LSU always wins a conflict.
module ram_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // instruction-fetch port
  input  logic        ifu_req_i,
  input  logic [14:0] ifu_addr_i,
  output logic        ifu_ack_o,
  output logic        ifu_err_o,
  output logic [31:0] ifu_rdata_o,
  // load/store port
  input  logic        lsu_read_i,
  input  logic        lsu_write_i,
  input  logic [14:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_byte_sel_i,
  output logic        lsu_ack_o,
  output logic        lsu_err_o,
  output logic [31:0] lsu_rdata_o,
  // SRAM wrapper
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [14:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_byte_select_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic GRANT_IFU = 1'b0;
  localparam logic GRANT_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               grant_r;
  logic               grant_s;
  logic               last_grant_r;
  logic               last_grant_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic               lsu_req_s;
  logic               any_req_s;
  logic               timeout_s;
  logic               pick_s;

  assign lsu_req_s = lsu_read_i | lsu_write_i;
  assign any_req_s = ifu_req_i | lsu_req_s;
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT));

  // Read data is a plain mirror of the wrapper; only the acked port uses it.
  assign ifu_rdata_o = mem_data_i;
  assign lsu_rdata_o = mem_data_i;

  // Choose the winner for a request seen in IDLE.
  always_comb begin
    pick_s = GRANT_IFU;
    if (ifu_req_i && lsu_req_s) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      pick_s = ~last_grant_r;
`else
      pick_s = GRANT_LSU;
`endif
    end else if (lsu_req_s) begin
      pick_s = GRANT_LSU;
    end else begin
      pick_s = GRANT_IFU;
    end
  end

  // State, grant, last grant and watchdog counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r      <= ST_IDLE;
      grant_r      <= GRANT_IFU;
      last_grant_r <= GRANT_LSU;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      grant_r      <= grant_s;
      last_grant_r <= last_grant_s;
      cnt_r        <= cnt_s;
    end
  end

  // Next-state logic: latch grant in IDLE, clear watchdog in ISSUE, finish in WAIT.
  always_comb begin
    state_s      = state_r;
    grant_s      = grant_r;
    last_grant_s = last_grant_r;
    cnt_s        = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          grant_s = pick_s;
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // The wrapper's ready is stale this cycle, so it is not looked at.
        cnt_s   = {CNT_W{1'b0}};
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_ready_i) begin
          last_grant_s = grant_r;
          state_s      = ST_IDLE;
        end else if (timeout_s) begin
          state_s = ST_IDLE;
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Outputs: the winner's request goes onto the wrapper bus while busy; acknowledge on completion.
  always_comb begin
    mem_read_o        = 1'b0;
    mem_write_o       = 1'b0;
    mem_addr_o        = 15'd0;
    mem_data_o        = 32'd0;
    mem_byte_select_o = 4'd0;
    ifu_ack_o         = 1'b0;
    ifu_err_o         = 1'b0;
    lsu_ack_o         = 1'b0;
    lsu_err_o         = 1'b0;
    case (state_r)
      ST_ISSUE, ST_WAIT: begin
        if (grant_r == GRANT_LSU) begin
          // A simultaneous read and write is treated as a write.
          mem_write_o       = lsu_write_i;
          mem_read_o        = lsu_read_i & ~lsu_write_i;
          mem_addr_o        = lsu_addr_i;
          mem_data_o        = lsu_wdata_i;
          mem_byte_select_o = lsu_byte_sel_i;
        end else begin
          mem_read_o        = 1'b1;
          mem_write_o       = 1'b0;
          mem_addr_o        = ifu_addr_i;
          mem_data_o        = 32'd0;
          mem_byte_select_o = 4'hF;
        end
        if ((state_r == ST_WAIT) && (mem_ready_i || timeout_s)) begin
          if (grant_r == GRANT_LSU) begin
            lsu_ack_o = 1'b1;
            lsu_err_o = ~mem_ready_i;
          end else begin
            ifu_ack_o = 1'b1;
            ifu_err_o = ~mem_ready_i;
          end
        end else begin
          ifu_ack_o = 1'b0;
          lsu_ack_o = 1'b0;
        end
      end
      default: begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Bench for ram_arbiter. A small SRAM wrapper model answers the arbiter. A
// transaction-level reference predicts the wrapper bus and the acknowledges
// every cycle. It tracks each access by its age since sampling and keeps its
// own copy of memory. Directed scenarios add literal expectations, and a
// randomized phase follows them.
module tb_ram_arbiter;

  localparam int TIMEOUT = 15;
`ifdef RAM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        ifu_req_i = 1'b0;
  logic [14:0] ifu_addr_i = 15'd0;
  logic        ifu_ack_o, ifu_err_o;
  logic [31:0] ifu_rdata_o;
  logic        lsu_read_i = 1'b0, lsu_write_i = 1'b0;
  logic [14:0] lsu_addr_i = 15'd0;
  logic [31:0] lsu_wdata_i = 32'd0;
  logic [3:0]  lsu_byte_sel_i = 4'd0;
  logic        lsu_ack_o, lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_read_o, mem_write_o;
  logic [14:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_byte_select_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_data_i;

  always #5 clk_i = ~clk_i;

  ram_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_ack_o(ifu_ack_o),
    .ifu_err_o(ifu_err_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_read_i(lsu_read_i), .lsu_write_i(lsu_write_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_byte_sel_i(lsu_byte_sel_i), .lsu_ack_o(lsu_ack_o),
    .lsu_err_o(lsu_err_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_byte_select_o(mem_byte_select_o),
    .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rdy_mode = 1;  // 0: never ready, 1: always ready, 2: random

  logic [31:0] sram    [0:32767];  // wrapper contents, written through the DUT
  logic [31:0] ref_mem [0:32767];  // reference contents

  // reference state
  bit m_busy = 1'b0;
  bit m_owner = 1'b0;   // 0 = IFU, 1 = LSU
  bit m_last = 1'b1;
  int m_age = 0;        // cycles since the request was sampled
  bit m_ifu_acked = 1'b0;
  bit m_lsu_acked = 1'b0;

  assign mem_data_i = sram[mem_addr_o];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // SRAM wrapper: memory init and byte-masked write on a ready write.
  initial begin : wrapper
    logic [31:0] w;
    for (int i = 0; i < 32768; i++) begin
      sram[i]    = {16'hA5A5, 1'b0, i[14:0]};
      ref_mem[i] = {16'hA5A5, 1'b0, i[14:0]};
    end
    forever begin
      @(posedge clk_i);
      if (mem_write_o && mem_ready_i) begin
        w = sram[mem_addr_o];
        for (int b = 0; b < 4; b++)
          if (mem_byte_select_o[b]) w[8*b +: 8] = mem_data_o[8*b +: 8];
        sram[mem_addr_o] <= w;
      end
    end
  end

  // Reference model and per-cycle compare.
  initial begin : model_cmp
    logic e_rd, e_wr, e_ia, e_la, e_err, e_chk_rd, done;
    logic [14:0] e_addr;
    logic [31:0] e_data, e_rdata, w;
    logic [3:0]  e_bs;
    forever begin
      @(negedge clk_i);
      e_rd = 1'b0; e_wr = 1'b0; e_ia = 1'b0; e_la = 1'b0; e_err = 1'b0; e_chk_rd = 1'b0;
      e_addr = 15'd0; e_data = 32'd0; e_bs = 4'd0; e_rdata = 32'd0;
      m_ifu_acked = 1'b0; m_lsu_acked = 1'b0;
      if (!rst_i) begin
        m_busy = 1'b0; m_last = 1'b1; m_age = 0;
      end else if (!m_busy) begin
        if (ifu_req_i || lsu_read_i || lsu_write_i) begin
          m_busy = 1'b1;
          m_age = 1;
          if (!(lsu_read_i || lsu_write_i)) m_owner = 1'b0;
          else if (!ifu_req_i) m_owner = 1'b1;
          else m_owner = RR_EN ? !m_last : 1'b1;
        end
      end else begin
        if (!m_owner) begin
          e_rd = 1'b1; e_addr = ifu_addr_i; e_bs = 4'hF;
        end else begin
          e_wr = lsu_write_i; e_rd = lsu_read_i && !lsu_write_i;
          e_addr = lsu_addr_i; e_data = lsu_wdata_i; e_bs = lsu_byte_sel_i;
        end
        done = (m_age >= 2) && (mem_ready_i || m_age == TIMEOUT + 2);
        if (done) begin
          e_err = !mem_ready_i;
          if (!m_owner) begin e_ia = 1'b1; m_ifu_acked = 1'b1; end
          else begin e_la = 1'b1; m_lsu_acked = 1'b1; end
          if (mem_ready_i) begin
            m_last = m_owner;
            if (e_wr) begin
              w = ref_mem[e_addr];
              for (int b = 0; b < 4; b++)
                if (e_bs[b]) w[8*b +: 8] = e_data[8*b +: 8];
              ref_mem[e_addr] = w;
            end else begin
              e_chk_rd = 1'b1;
              e_rdata = ref_mem[e_addr];
            end
          end
          m_busy = 1'b0;
        end else begin
          m_age++;
        end
      end
      chk("mem_read", mem_read_o, e_rd);
      chk("mem_write", mem_write_o, e_wr);
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_data", mem_data_o, e_data);
      chk("mem_bsel", mem_byte_select_o, e_bs);
      chk("ifu_ack", ifu_ack_o, e_ia);
      chk("lsu_ack", lsu_ack_o, e_la);
      chk("ifu_rdata_mirror", ifu_rdata_o, mem_data_i);
      chk("lsu_rdata_mirror", lsu_rdata_o, mem_data_i);
      if (e_ia || e_la) chk("ack_err", e_ia ? ifu_err_o : lsu_err_o, e_err);
      if (e_chk_rd) chk("ack_rdata", e_ia ? ifu_rdata_o : lsu_rdata_o, e_rdata);
    end
  end

  task automatic drive_ready();
    if (m_busy && m_age == 1) mem_ready_i = 1'b0;  // wrapper drops ready on a new access
    else if (rdy_mode == 0) mem_ready_i = 1'b0;
    else if (rdy_mode == 1) mem_ready_i = 1'b1;
    else mem_ready_i = ($urandom_range(0, 2) != 0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    drive_ready();
  endtask

  // Run from the current cycle (0) until the port acks or the budget expires.
  task automatic run_until_ack(input bit port, input int budget, output int lat,
                               output logic [31:0] rdata, output logic err,
                               output logic [31:0] rd_hist);
    lat = -1; rdata = 32'd0; err = 1'bx; rd_hist = 32'd0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk_i);
      if (n < 32) rd_hist[n] = mem_read_o;
      if (port ? lsu_ack_o : ifu_ack_o) begin
        lat = n;
        rdata = port ? lsu_rdata_o : ifu_rdata_o;
        err = port ? lsu_err_o : ifu_err_o;
        break;
      end
      tick();
    end
  endtask

  task automatic release_all();
    tick();
    ifu_req_i = 1'b0; lsu_read_i = 1'b0; lsu_write_i = 1'b0;
    tick();
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin : stim
    int lat;
    int nack;
    logic [31:0] rd, hist;
    logic er;
    logic [5:0] seq;
    logic [5:0] exp_seq;
    exp_seq = RR_EN ? 6'b101010 : 6'b111111;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_mem_read", mem_read_o, 1'b0);
    chk("rst_ifu_ack", ifu_ack_o, 1'b0);
    chk("rst_bsel", mem_byte_select_o, 4'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    tick();

    // IFU read of 0x0010
    rdy_mode = 1;
    ifu_req_i = 1'b1; ifu_addr_i = 15'h0010;
    run_until_ack(1'b0, 30, lat, rd, er, hist);
    chk("t1_latency", lat, 2);
    chk("t1_rdata", rd, 32'hA5A50010);
    chk("t1_err", er, 1'b0);
    chk("t1_read_strobe", hist, 32'h0000_0006);
    release_all();

    // LSU partial write then read back
    lsu_write_i = 1'b1; lsu_addr_i = 15'h1234; lsu_wdata_i = 32'hDEADBEEF; lsu_byte_sel_i = 4'b0011;
    run_until_ack(1'b1, 30, lat, rd, er, hist);
    chk("t2w_latency", lat, 2);
    chk("t2w_err", er, 1'b0);
    release_all();
    lsu_read_i = 1'b1; lsu_addr_i = 15'h1234;
    run_until_ack(1'b1, 30, lat, rd, er, hist);
    chk("t2r_latency", lat, 2);
    chk("t2r_rdata", rd, 32'hA5A5BEEF);
    chk("t2r_idle_gap", hist[0], 1'b0);
    release_all();

    // Both ports requesting continuously
    ifu_req_i = 1'b1; ifu_addr_i = 15'h0003;
    lsu_read_i = 1'b1; lsu_addr_i = 15'h0004;
    seq = 6'd0; nack = 0;
    for (int n = 0; n < 40 && nack < 6; n++) begin
      @(negedge clk_i);
      if (ifu_ack_o || lsu_ack_o) begin
        seq[nack] = lsu_ack_o;
        nack++;
      end
      tick();
    end
    chk("arb_ack_count", nack, 6);
    chk("arb_order", seq, exp_seq);
    ifu_req_i = 1'b0; lsu_read_i = 1'b0;
    tick();

    // Watchdog abort, then a normal access
    rdy_mode = 0;
    ifu_req_i = 1'b1; ifu_addr_i = 15'h0022;
    run_until_ack(1'b0, 40, lat, rd, er, hist);
    chk("t4_timeout_latency", lat, 17);
    chk("t4_timeout_err", er, 1'b1);
    chk("t4_read_strobe", hist, 32'h0003_FFFE);
    rdy_mode = 1;
    release_all();
    lsu_read_i = 1'b1; lsu_addr_i = 15'h0010;
    run_until_ack(1'b1, 30, lat, rd, er, hist);
    chk("t4_next_latency", lat, 2);
    chk("t4_next_err", er, 1'b0);
    chk("t4_next_rdata", rd, 32'hA5A50010);
    release_all();

    // Reset while waiting
    rdy_mode = 0;
    ifu_req_i = 1'b1; ifu_addr_i = 15'h0005;
    tick(); tick(); tick();
    chk("t5_pre_reset_read", mem_read_o, 1'b1);
    rst_i = 1'b0;
    #1;
    chk("t5_reset_read", mem_read_o, 1'b0);
    chk("t5_reset_write", mem_write_o, 1'b0);
    chk("t5_reset_ack", ifu_ack_o, 1'b0);
    ifu_req_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rdy_mode = 1;
    ifu_req_i = 1'b1; ifu_addr_i = 15'h1234;
    run_until_ack(1'b0, 30, lat, rd, er, hist);
    chk("t5_after_latency", lat, 2);
    chk("t5_after_rdata", rd, 32'hA5A5BEEF);
    release_all();

    // LSU read and write together is a write
    lsu_read_i = 1'b1; lsu_write_i = 1'b1; lsu_addr_i = 15'h0040;
    lsu_wdata_i = 32'h12345678; lsu_byte_sel_i = 4'hF;
    run_until_ack(1'b1, 30, lat, rd, er, hist);
    chk("t6_latency", lat, 2);
    chk("t6_no_read", hist, 32'd0);
    chk("t6_err", er, 1'b0);
    release_all();
    lsu_read_i = 1'b1; lsu_addr_i = 15'h0040;
    run_until_ack(1'b1, 30, lat, rd, er, hist);
    chk("t6_readback", rd, 32'h12345678);
    release_all();

    // Randomized traffic, checked every cycle by the reference
    rdy_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      tick();
      if (ifu_req_i && m_ifu_acked) ifu_req_i = 1'b0;
      if ((lsu_read_i || lsu_write_i) && m_lsu_acked) begin
        lsu_read_i = 1'b0; lsu_write_i = 1'b0;
      end
      if (!ifu_req_i && $urandom_range(0, 2) == 0) begin
        ifu_req_i = 1'b1;
        ifu_addr_i = 15'($urandom_range(0, 31));
      end
      if (!(lsu_read_i || lsu_write_i) && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    begin lsu_read_i = 1'b1; lsu_write_i = 1'b0; end
          2:       begin lsu_read_i = 1'b0; lsu_write_i = 1'b1; end
          default: begin lsu_read_i = 1'b1; lsu_write_i = 1'b1; end
        endcase
        lsu_addr_i = 15'($urandom_range(0, 31));
        lsu_wdata_i = $urandom;
        lsu_byte_sel_i = 4'($urandom_range(0, 15));
      end
    end
    rdy_mode = 1;
    repeat (TIMEOUT + 4) begin
      tick();
      if (ifu_req_i && m_ifu_acked) ifu_req_i = 1'b0;
      if ((lsu_read_i || lsu_write_i) && m_lsu_acked) begin
        lsu_read_i = 1'b0; lsu_write_i = 1'b0;
      end
    end
    ifu_req_i = 1'b0; lsu_read_i = 1'b0; lsu_write_i = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard stop if the run somehow never completes.
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion before time limit");
    $fatal(1, "simulation time limit");
  end

endmodule
